// File: rtl/shift_pkg.sv
// Shared types and default sizes for the shift sequencer and its step counter.
package shift_pkg;
   localparam int WIDTH = 4;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_SHL  = 2'b01,
      OP_SHR  = 2'b10,
      OP_NOP  = 2'b11
   } shift_op_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } seq_state_t;
endpackage

// File: rtl/step_counter.sv
// Loadable down-counter; last flags the final step of a shift command.
module step_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign last = (cnt == CNT_W'(1));
endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer driving an external 4-bit shifter one step per cycle and
// registering its result.
//
//   state  | meaning
//   S_IDLE | waiting for a command; shifter controls low so it passes q through
//   S_RUN  | stepping the shifter in direction dir until the counter expires
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH = shift_pkg::WIDTH,
   parameter int CNT_W = shift_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [WIDTH-1:0] sh_i,
   output logic             sh_l,
   output logic             sh_r,
   input  logic [WIDTH-1:0] sh_o,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);
   seq_state_t       state;
   shift_op_t        dir;
   shift_op_t        op;
   logic             accept;
   logic             is_shift;
   logic             cnt_load;
   logic             last;
   logic [CNT_W-1:0] cnt;

   assign op        = shift_op_t'(cmd_op);
   assign cmd_ready = (state == S_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign is_shift  = (op == OP_SHL) || (op == OP_SHR);
   assign cnt_load  = accept && is_shift && (cmd_count != '0);

   step_counter #(.CNT_W(CNT_W)) u_step_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cmd_count),
      .dec      (state == S_RUN),
      .cnt      (cnt),
      .last     (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         dir   <= OP_NOP;
         q     <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (op == OP_LOAD) begin
                     q    <= cmd_data;
                     done <= 1'b1;
                  end else if (cnt_load) begin
                     dir   <= op;
                     state <= S_RUN;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               q <= sh_o;
               if (last) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Direction decode is gated by RUN so the shifter is transparent in IDLE.
   assign sh_l = (state == S_RUN) && (dir == OP_SHL);
   assign sh_r = (state == S_RUN) && (dir == OP_SHR);
   assign sh_i = q;
   assign busy = (state == S_RUN);
endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer with an attached shifter model.
module tb_shift_sequencer;
   localparam int W = 4;
   localparam int C = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_data;
   logic [C-1:0] cmd_count;
   logic [W-1:0] sh_i;
   logic         sh_l;
   logic         sh_r;
   logic [W-1:0] sh_o;
   logic [W-1:0] q;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;
   int mq     = 0;

   always #5 clk = ~clk;

   // External combinational shifter
   assign sh_o = sh_l ? (sh_i << 1) : (sh_r ? (sh_i >> 1) : sh_i);

   shift_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .sh_i      (sh_i),
      .sh_l      (sh_l),
      .sh_r      (sh_r),
      .sh_o      (sh_o),
      .q         (q),
      .busy      (busy),
      .done      (done)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Value after k single-bit steps: zeros shift in, no wrap.
   function automatic int shifted(input int v, input int op, input int k);
      if (op == 1) return (v * (1 << k)) % 16;
      return v / (1 << k);
   endfunction

   task automatic issue(input int op, input int data, input int count);
      cmd_op    = op[1:0];
      cmd_data  = data[W-1:0];
      cmd_count = count[C-1:0];
      cmd_valid = 1'b1;
   endtask

   task automatic accept();
      int n = 0;
      while (!cmd_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Called #1 after the accepting edge; ends #1 after the done edge.
   task automatic follow(input int op, input int data, input int count);
      if (op == 0) mq = data;
      if ((op == 1 || op == 2) && count > 0) begin
         for (int k = 0; k < count; k++) begin
            check("run_busy", busy, 1);
            check("run_ready", cmd_ready, 0);
            check("run_done", done, 0);
            check("run_q", q, shifted(mq, op, k));
            check("run_sh_l", sh_l, op == 1);
            check("run_sh_r", sh_r, op == 2);
            @(posedge clk); #1;
         end
         mq = shifted(mq, op, count);
      end
      check("end_q", q, mq);
      check("end_sh_i", sh_i, mq);
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_ready", cmd_ready, 1);
      check("end_ctl", {sh_l, sh_r}, 0);
   endtask

   task automatic run_cmd(input int op, input int data, input int count);
      issue(op, data, count);
      accept();
      follow(op, data, count);
   endtask

   task automatic idle_check();
      @(posedge clk); #1;
      check("done_width", done, 0);
      check("idle_busy", busy, 0);
      check("idle_q", q, mq);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b1;
      cmd_op = 2'b00;
      cmd_data = 4'hF;
      cmd_count = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q", q, 0);
      check("rst_ready", cmd_ready, 0);
      check("rst_ctl", {sh_l, sh_r}, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      cmd_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("post_rst_ready", cmd_ready, 1);
      mq = 0;

      run_cmd(0, 4'b1011, 0);
      idle_check();
      run_cmd(0, 4'b0001, 0);
      run_cmd(1, 0, 2);
      idle_check();
      run_cmd(0, 4'b1111, 0);
      run_cmd(2, 0, 5);
      idle_check();
      run_cmd(3, 4'b0110, 3);
      idle_check();
      run_cmd(1, 4'b1001, 0);
      idle_check();

      // LOAD held valid across a running shift, taken in the done cycle
      run_cmd(0, 4'b0011, 0);
      issue(1, 0, 3);
      accept();
      issue(0, 4'b1010, 0);
      follow(1, 0, 3);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      follow(0, 4'b1010, 0);
      idle_check();

      // Reset two steps into a four-step shift
      run_cmd(0, 4'b1000, 0);
      issue(2, 0, 4);
      accept();
      repeat (2) @(posedge clk);
      #1;
      check("mid_q", q, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_q", q, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_ready", cmd_ready, 0);
      rst = 1'b0;
      #1;
      check("mid_rel_ready", cmd_ready, 1);
      mq = 0;
      @(posedge clk); #1;
      check("mid_no_done", done, 0);
      check("mid_idle_q", q, 0);

      for (int i = 0; i < 40; i++) begin
         int op  = $urandom_range(0, 3);
         int d   = $urandom_range(0, 15);
         int c   = $urandom_range(0, 7);
         int gap = $urandom_range(0, 2);
         run_cmd(op, d, c);
         if (gap > 0) idle_check();
         if (gap > 1) idle_check();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
